// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-domain side of an 8-deep async FIFO.
// Drives RAM writes, publishes the Gray write pointer, derives full/level from the synchronised read pointer.
module fifo_wr_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6
) (
    input  logic              clr,
    input  logic              wr_clk,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [ADDR_W:0]   rd_ptr_gray,
    input  logic              ovf_clr,
    output logic              we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] data_in,
    output logic [ADDR_W:0]   wr_ptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              overflow
);
    logic [ADDR_W:0] wr_bin, next_bin, next_gray, next_level, rq1, rq2, rd_bin;

    for (genvar i = 0; i <= ADDR_W; i++) begin : g_g2b
        assign rd_bin[i] = ^rq2[ADDR_W:i];
    end

    assign we         = push & ~full & ~clr;
    assign wr_addr    = wr_bin[ADDR_W-1:0];
    assign data_in    = push_data;
    assign next_bin   = wr_bin + {{ADDR_W{1'b0}}, we};
    assign next_gray  = next_bin ^ (next_bin >> 1);
    assign next_level = next_bin - rd_bin;

    // full compares against the twice-synchronised read pointer, so it can only be late, never early
    always_ff @(posedge wr_clk or posedge clr) begin
        if (clr) begin
            rq1         <= '0;
            rq2         <= '0;
            wr_bin      <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
            wr_level    <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            rq1         <= rd_ptr_gray;
            rq2         <= rq1;
            wr_bin      <= next_bin;
            wr_ptr_gray <= next_gray;
            full        <= next_gray == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]};
            wr_level    <= next_level;
            almost_full <= next_level >= (ADDR_W+1)'(AF_LEVEL);
            overflow    <= (push & full) | (overflow & ~ovf_clr);
        end
    end
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed and random traffic; a monitor scoreboards RAM writes against issued pushes.
module tb_fifo_wr_ctrl;
    logic        clr, wr_clk = 1'b0, push, ovf_clr;
    logic [15:0] push_data, data_in;
    logic [3:0]  rd_ptr_gray, wr_ptr_gray, wr_level;
    logic [2:0]  wr_addr;
    logic        we, full, almost_full, overflow;

    logic [3:0]  m_wr, m_rs1, m_rs2, m_lvl, rd_bin, occ_m;
    logic        m_full, m_ovf;
    logic [18:0] exp_q[$];
    logic [15:0] ord_q[$];
    logic [15:0] ram[8];
    logic [18:0] e_m;
    int          tests = 0, fails = 0;

    fifo_wr_ctrl dut (
        .clr(clr), .wr_clk(wr_clk), .push(push), .push_data(push_data),
        .rd_ptr_gray(rd_ptr_gray), .ovf_clr(ovf_clr), .we(we), .wr_addr(wr_addr),
        .data_in(data_in), .wr_ptr_gray(wr_ptr_gray), .full(full),
        .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // scoreboard monitor: every RAM write must match the oldest accepted push and hit a free slot
    always @(negedge wr_clk) begin
        if (we) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, data_in);
            end else begin
                e_m = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e_m[18:16]));
                chk("data_in", 32'(data_in), 32'(e_m[15:0]));
            end
            occ_m = m_wr - rd_bin;
            chk("no_overwrite", 32'(occ_m < 4'd8), 32'd1);
            ram[wr_addr] = data_in;
        end
    end

    task automatic model_reset();
        m_wr = 0; m_rs1 = 0; m_rs2 = 0; m_lvl = 0; rd_bin = 0;
        m_full = 0; m_ovf = 0;
        exp_q.delete();
        ord_q.delete();
    endtask

    task automatic step(input logic p, input logic [15:0] d, input logic oc);
        logic acc;
        push = p; push_data = d; ovf_clr = oc;
        rd_ptr_gray = rd_bin ^ (rd_bin >> 1);
        acc = p & ~m_full;
        if (acc) begin
            exp_q.push_back({m_wr[2:0], d});
            ord_q.push_back(d);
        end
        #2 chk("we", 32'(we), 32'(acc));
        @(posedge wr_clk);
        #1;
        m_wr  = m_wr + 4'(acc);
        m_lvl = m_wr - m_rs2;
        m_rs2 = m_rs1;
        m_rs1 = rd_bin;
        m_full = m_lvl == 4'd8;
        m_ovf  = (p & ~acc) | (m_ovf & ~oc);
        chk("full", 32'(full), 32'(m_full));
        chk("wr_level", 32'(wr_level), 32'(m_lvl));
        chk("almost_full", 32'(almost_full), 32'(m_lvl >= 4'd6));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("wr_ptr_gray", 32'(wr_ptr_gray), 32'(m_wr ^ (m_wr >> 1)));
    endtask

    task automatic rd_adv(input int n);
        for (int k = 0; k < n; k++) begin
            chk("rd_data", 32'(ram[rd_bin[2:0]]), 32'(ord_q.pop_front()));
            rd_bin = rd_bin + 4'd1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        clr = 1; push = 1; push_data = 16'h1234; ovf_clr = 0; rd_ptr_gray = 0;
        model_reset();
        #1;
        chk("rst_we", 32'(we), 0);
        chk("rst_addr", 32'(wr_addr), 0);
        chk("rst_level", 32'(wr_level), 0);
        chk("rst_gray", 32'(wr_ptr_gray), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_af", 32'(almost_full), 0);
        repeat (2) @(posedge wr_clk);
        #1 clr = 0; push = 0;
        chk("rst_push_no_ovf", 32'(overflow), 0);
        for (int i = 0; i < 3; i++) step(1, 16'ha000 + 16'(i), 0);
        chk("burst_level", 32'(wr_level), 3);
        chk("burst_addr", 32'(wr_addr), 3);
        push = 1;
        #1 clr = 1;
        #1;
        chk("midrst_addr", 32'(wr_addr), 0);
        chk("midrst_level", 32'(wr_level), 0);
        chk("midrst_gray", 32'(wr_ptr_gray), 0);
        chk("midrst_full", 32'(full), 0);
        chk("midrst_ovf", 32'(overflow), 0);
        chk("midrst_we", 32'(we), 0);
        model_reset();
        @(posedge wr_clk);
        #1 clr = 0; push = 0;
        chk("midrst_edge_ovf", 32'(overflow), 0);
        for (int i = 1; i <= 8; i++) begin
            step(1, 16'hb000 + 16'(i), 0);
            chk("fill_af", 32'(almost_full), 32'(i >= 6));
            chk("fill_full", 32'(full), 32'(i == 8));
            chk("fill_level", 32'(wr_level), 32'(i));
        end
        chk("fill_gray", 32'(wr_ptr_gray), 32'b1100);
        step(1, 16'hdead, 0);
        chk("ovf_addr", 32'(wr_addr), 0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_level", 32'(wr_level), 8);
        step(0, 0, 1);
        chk("ovf_clr", 32'(overflow), 0);
        step(1, 16'hbeef, 1);
        chk("ovf_set_wins", 32'(overflow), 1);
        step(0, 0, 1);
        rd_adv(1);
        step(0, 0, 0);
        chk("drain_e1_full", 32'(full), 1);
        step(0, 0, 0);
        chk("drain_e2_full", 32'(full), 1);
        chk("drain_e2_level", 32'(wr_level), 8);
        step(0, 0, 0);
        chk("drain_e3_full", 32'(full), 0);
        chk("drain_e3_level", 32'(wr_level), 7);
        rd_adv(7);
        repeat (3) step(0, 0, 0);
        chk("empty_level", 32'(wr_level), 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 16'hc000 + 16'(i), 0);
            chk("wrap_no_full", 32'(full), 0);
            chk("wrap_level_max", 32'(wr_level <= 4'd8), 1);
            rd_adv(1);
            step(0, 0, 0);
        end
        chk("wrap_addr", 32'(wr_addr), 4);
        chk("wrap_gray", 32'(wr_ptr_gray), 32'b1010);
        for (int i = 0; i < 300; i++) begin
            if (ord_q.size() > 0 && $urandom_range(1) == 1) rd_adv(1);
            step(1'($urandom_range(1)), 16'($urandom), $urandom_range(7) == 0);
        end
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
